// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lock_controller
//  Purpose  : Access decision, timed unlock window, lockout and latched alarm.
//  Revision : 1.0  initial release
// ============================================================================
module lock_controller #(
  parameter int MAX_FAILS      = 3,
  parameter int MAX_LOCKOUTS   = 2,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       check_i,
  input  logic       valid_i,
  input  logic       relock_i,
  output logic       unlock_o,
  output logic       locked_out_o,
  output logic       alarm_o,
  output logic       ack_o,
  output logic [3:0] fail_count_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPEN    = 2'd1,
    S_LOCKOUT = 2'd2,
    S_ALARM   = 2'd3
  } state_e;

  localparam logic [3:0]         C_FAIL_LAST    = 4'(MAX_FAILS - 1);
  localparam logic [3:0]         C_LOCK_LAST    = 4'(MAX_LOCKOUTS - 1);
  localparam logic [TIMER_W-1:0] C_UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);

  state_e             state_q;
  logic [TIMER_W-1:0] timer_q;
  logic [3:0]         fail_q;
  logic [3:0]         lock_cnt_q;
  logic               unlock_q;
  logic               locked_q;
  logic               alarm_q;
  logic               ack_q;

  // Outputs are updated together with the state so they appear the cycle
  // after the deciding edge and never glitch on a combinational path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      unlock_q   <= 1'b0;
      locked_q   <= 1'b0;
      alarm_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (check_i) begin
            ack_q <= 1'b1;
            if (valid_i) begin
              state_q    <= S_OPEN;
              timer_q    <= C_UNLOCK_LOAD;
              fail_q     <= '0;
              lock_cnt_q <= '0;
              unlock_q   <= 1'b1;
            end else if (fail_q < C_FAIL_LAST) begin
              fail_q <= fail_q + 4'd1;
            end else if (lock_cnt_q == C_LOCK_LAST) begin
              fail_q  <= '0;
              state_q <= S_ALARM;
              alarm_q <= 1'b1;
            end else begin
              fail_q     <= '0;
              lock_cnt_q <= lock_cnt_q + 4'd1;
              timer_q    <= C_LOCKOUT_LOAD;
              state_q    <= S_LOCKOUT;
              locked_q   <= 1'b1;
            end
          end
        end
        S_OPEN: begin
          if (relock_i || (timer_q == '0)) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        S_LOCKOUT: begin
          // Lockout counter is deliberately held so the next fail run escalates.
          if (timer_q == '0) begin
            state_q  <= S_IDLE;
            locked_q <= 1'b0;
          end else begin
            timer_q <= timer_q - TIMER_W'(1);
          end
        end
        S_ALARM: begin
          alarm_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unlock_o     = unlock_q;
  assign locked_out_o = locked_q;
  assign alarm_o      = alarm_q;
  assign ack_o        = ack_q;
  assign fail_count_o = fail_q;

endmodule
`default_nettype wire

// File: doc/lock_controller.md
# lock_controller

Access-decision stage directly downstream of the password/profile checker. Samples the checker's `valid` result on a one-cycle `check` strobe and drives the physical unlock for a fixed window. Counts consecutive failed attempts and enforces a timed lockout; repeated lockouts escalate to a latched alarm that only reset clears.

## Interface
- `MAX_FAILS`, 3: consecutive failed checks that trigger a lockout; legal range 1..15.
- `MAX_LOCKOUTS`, 2: consecutive lockouts that trigger the alarm; legal range 1..15.
- `UNLOCK_CYCLES`, 8: cycles `unlock` stays high per successful check; range 1..2^TIMER_W.
- `LOCKOUT_CYCLES`, 16: cycles `locked_out` stays high per lockout; range 1..2^TIMER_W.
- `TIMER_W`, 8: width of the shared down-counter.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `check`  input  1  one-cycle strobe; `valid` is the result of an attempt this cycle.
- `valid`  input  1  checker match result; sampled only when `check`=1.
- `relock`  input  1  closes an open window early.
- `unlock`  output  1  lock actuator drive.
- `locked_out`  output  1  lockout in progress.
- `alarm`  output  1  latched alarm.
- `ack`  output  1  one-cycle pulse acknowledging an accepted check.
- `fail_count`  output  4  current consecutive-fail count.

## Operation
- States: IDLE, OPEN, LOCKOUT, ALARM. All outputs are registered.
- IDLE, `check`=1, `valid`=1:
  - go to OPEN; load timer with UNLOCK_CYCLES-1.
  - clear fail counter and lockout counter.
  - `ack` pulses.
- IDLE, `check`=1, `valid`=0:
  - `ack` pulses.
  - If fail_count < MAX_FAILS-1: increment fail_count; stay in IDLE.
  - Else, if lockout counter = MAX_LOCKOUTS-1: clear fail_count; go to ALARM.
  - Else: clear fail_count; increment lockout counter; load timer with LOCKOUT_CYCLES-1; go to LOCKOUT.
- IDLE, `check`=0: no change.
- OPEN:
  - `unlock`=1.
  - Timer decrements each cycle; at timer=0 go to IDLE.
  - `relock`=1 goes to IDLE next edge, regardless of timer.
  - `check` is ignored: no `ack`, counters unchanged.
- LOCKOUT:
  - `locked_out`=1.
  - Timer decrements; at timer=0 go to IDLE.
  - `check` and `relock` are ignored; no `ack`.
  - Lockout counter is held, so the next fail run can escalate.
- ALARM:
  - `alarm`=1; all inputs ignored.
  - Exits only on `rst`.
- `relock` is ignored outside OPEN.
- Counter widths: fail and lockout counters are 4 bits and never wrap, because they are bounded by the parameter ranges. The timer never underflows.
- `fail_count` mirrors the fail counter; it is 0 in OPEN, LOCKOUT and ALARM.

## Timing
- Reset values: state=IDLE; `unlock`=0, `locked_out`=0, `alarm`=0, `ack`=0, `fail_count`=0; timer=0; lockout counter=0.
- `rst` overrides everything, including mid-window or in ALARM; outputs are at reset values the cycle after the edge where `rst`=1.
- `check` at edge k:
  - `ack` is high during cycle k+1 only.
  - `fail_count` is updated in cycle k+1.
  - OPEN/LOCKOUT/ALARM outputs rise in cycle k+1.
- `unlock` is high for exactly UNLOCK_CYCLES cycles (k+1..k+UNLOCK_CYCLES), then IDLE.
- `locked_out` is high for exactly LOCKOUT_CYCLES cycles.
- First cycle back in IDLE: a `check` is accepted normally, giving back-to-back service.
- `relock` sampled at edge j in OPEN: `unlock` is low from cycle j+1.
- `relock` on the same edge as timer=0: go to IDLE (same result).
- `check` held high for several cycles in IDLE: each cycle counts as a separate attempt. The upstream stage must issue single-cycle strobes.
- Upstream `valid` must already reflect the attempt on the edge where `check`=1.

## Test plan
- Reset, then `check`=1 with `valid`=1 at edge 5 (defaults):
  - `ack` high cycle 6 only; `unlock` high cycles 6..13, low at 14; `fail_count`=0 throughout.
- Three strobes with `valid`=0, two cycles apart:
  - `fail_count` steps 1, 2, then 0.
  - `locked_out` high for exactly 16 cycles; strobes during lockout give no `ack` and no count change.
- Two full fail runs with no success between:
  - first run produces LOCKOUT; second run's third fail asserts `alarm`.
  - `alarm` stays high 100 cycles despite `check`/`valid`=1; `rst` clears it.
- Unlock, then `relock` on the 3rd open cycle:
  - `unlock` low the following cycle.
  - `check`/`valid`=1 on the next cycle reopens the window with a full 8 cycles.
- Two fails, one success, then two fails:
  - `fail_count` goes 1, 2, 0, 1, 2; no lockout occurs.
- `rst` asserted mid-LOCKOUT and mid-OPEN:
  - all outputs 0 and `fail_count`=0 the next cycle.
  - lockout counter is cleared: two further fail runs are needed to reach ALARM.
